// File: rtl/pc_regs_pkg.sv
// Shared register-file types for the port scheduler and its write queue.
package pc_regs_pkg;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        reg_idx_t rd;
        word_t    data;
    } wq_entry_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // Exactly one use of the shared addr_b port per cycle.
    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_READ,
        SLOT_DRAIN
    } slot_t;

    typedef enum logic {
        SRC_MEM,
        SRC_ALU
    } wb_src_t;

endpackage

// File: rtl/regfile_port_sched_if.sv
// Decode, writeback and register-file bus signals of the port scheduler.
interface regfile_port_sched_if #(
    parameter int WQ_DEPTH = 4
);
    import pc_regs_pkg::*;

    logic                      rd_req_valid;
    logic                      rd_req_ready;
    reg_idx_t                  rd_rs1;
    reg_idx_t                  rd_rs2;
    logic                      rd_rsp_valid;
    word_t                     rd_rsp_a;
    word_t                     rd_rsp_b;
    logic                      alu_wb_valid;
    logic                      alu_wb_ready;
    reg_idx_t                  alu_wb_rd;
    word_t                     alu_wb_data;
    logic                      mem_wb_valid;
    logic                      mem_wb_ready;
    reg_idx_t                  mem_wb_rd;
    word_t                     mem_wb_data;
    logic                      rf_we;
    reg_idx_t                  rf_addr_a;
    reg_idx_t                  rf_addr_b;
    word_t                     rf_din;
    word_t                     rf_reg_a;
    word_t                     rf_reg_b;
    logic [$clog2(WQ_DEPTH):0] wq_level;

    modport master (
        output rd_req_valid, rd_rs1, rd_rs2,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output mem_wb_valid, mem_wb_rd, mem_wb_data,
        output rf_reg_a, rf_reg_b,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_a, rd_rsp_b,
        input  alu_wb_ready, mem_wb_ready,
        input  rf_we, rf_addr_a, rf_addr_b, rf_din, wq_level
    );

    modport slave (
        input  rd_req_valid, rd_rs1, rd_rs2,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  mem_wb_valid, mem_wb_rd, mem_wb_data,
        input  rf_reg_a, rf_reg_b,
        output rd_req_ready, rd_rsp_valid, rd_rsp_a, rd_rsp_b,
        output alu_wb_ready, mem_wb_ready,
        output rf_we, rf_addr_a, rf_addr_b, rf_din, wq_level
    );

endinterface

// File: rtl/regfile_wq.sv
// Circular writeback queue with two youngest-match bypass lookup ports.
module regfile_wq
    import pc_regs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wq_entry_t              push_entry,
    input  logic                   pop,
    output wq_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    input  reg_idx_t               idx_a,
    output logic                   hit_a,
    output word_t                  data_a,
    input  reg_idx_t               idx_b,
    output logic                   hit_b,
    output word_t                  data_b
);
    localparam int AW = $clog2(DEPTH);

    wq_entry_t     mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] scan_idx;

    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

    // Scan oldest to youngest so the last match seen is the youngest.
    always_comb begin
        hit_a    = 1'b0;
        data_a   = '0;
        hit_b    = 1'b0;
        data_b   = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr[AW-1:0] + AW'(i);
            if ((AW+1)'(i) < level) begin
                if (mem[scan_idx].rd == idx_a) begin
                    hit_a  = 1'b1;
                    data_a = mem[scan_idx].data;
                end
                if (mem[scan_idx].rd == idx_b) begin
                    hit_b  = 1'b1;
                    data_b = mem[scan_idx].data;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_port_sched.sv
// Register-file port scheduler: arbitrates writebacks into a queue, shares addr_b
// between operand reads and queue drains, and bypasses queued data to decode.
module regfile_port_sched
    import pc_regs_pkg::*;
#(
    parameter int WQ_DEPTH        = 4,
    parameter int MAX_READ_STREAK = 8
) (
    input logic                 clk,
    input logic                 rst,
    regfile_port_sched_if.slave bus
);
    localparam int LW = $clog2(WQ_DEPTH) + 1;
    localparam int SW = $clog2(MAX_READ_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_READ_STREAK);

    slot_t         slot;
    wb_src_t       rr_q;
    logic [SW-1:0] streak_q;
    logic          wq_full;
    logic          wq_empty;
    logic [LW-1:0] level;
    wq_entry_t     head;
    wq_entry_t     push_entry;
    logic          push;
    logic          grant_mem;
    logic          grant_alu;
    logic          space;
    logic          hit_a;
    logic          hit_b;
    word_t         byp_a;
    word_t         byp_b;
    word_t         opnd_a;
    word_t         opnd_b;

    regfile_wq #(.DEPTH(WQ_DEPTH)) u_wq (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (slot == SLOT_DRAIN),
        .head       (head),
        .full       (wq_full),
        .empty      (wq_empty),
        .level      (level),
        .idx_a      (bus.rd_rs1),
        .hit_a      (hit_a),
        .data_a     (byp_a),
        .idx_b      (bus.rd_rs2),
        .hit_b      (hit_b),
        .data_b     (byp_b)
    );

    assign bus.wq_level = level;

    // A drain wins whenever decode is quiet, the queue is full or reads have starved it.
    always_comb begin
        slot = SLOT_IDLE;
        if (!rst) begin
            slot = SLOT_IDLE;
        end else if (!wq_empty && (!bus.rd_req_valid || wq_full || streak_q == STREAK_MAX)) begin
            slot = SLOT_DRAIN;
        end else if (bus.rd_req_valid) begin
            slot = SLOT_READ;
        end
    end

    always_comb begin
        grant_mem        = bus.mem_wb_valid && (!bus.alu_wb_valid || rr_q == SRC_MEM);
        grant_alu        = bus.alu_wb_valid && !grant_mem;
        space            = rst && (!wq_full || slot == SLOT_DRAIN);
        bus.mem_wb_ready = grant_mem && space;
        bus.alu_wb_ready = grant_alu && space;
        push_entry.rd    = grant_mem ? bus.mem_wb_rd : bus.alu_wb_rd;
        push_entry.data  = grant_mem ? bus.mem_wb_data : bus.alu_wb_data;
        push             = (grant_alu || grant_mem) && space && (push_entry.rd != REG_ZERO);
    end

    always_comb begin
        opnd_a = hit_a ? byp_a : bus.rf_reg_a;
        opnd_b = hit_b ? byp_b : bus.rf_reg_b;
        if (bus.rd_rs1 == REG_ZERO) opnd_a = '0;
        if (bus.rd_rs2 == REG_ZERO) opnd_b = '0;
        bus.rd_req_ready = (slot == SLOT_READ);
        bus.rf_we        = (slot == SLOT_DRAIN);
        bus.rf_addr_a    = rst ? bus.rd_rs1 : REG_ZERO;
        bus.rf_addr_b    = REG_ZERO;
        bus.rf_din       = '0;
        if (slot == SLOT_DRAIN) begin
            bus.rf_addr_b = head.rd;
            bus.rf_din    = head.data;
        end else if (rst) begin
            bus.rf_addr_b = bus.rd_rs2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rd_rsp_valid <= 1'b0;
            bus.rd_rsp_a     <= '0;
            bus.rd_rsp_b     <= '0;
        end else begin
            bus.rd_rsp_valid <= (slot == SLOT_READ);
            if (slot == SLOT_READ) begin
                bus.rd_rsp_a <= opnd_a;
                bus.rd_rsp_b <= opnd_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q     <= SRC_MEM;
            streak_q <= '0;
        end else begin
            if (bus.mem_wb_ready) begin
                rr_q <= SRC_ALU;
            end else if (bus.alu_wb_ready) begin
                rr_q <= SRC_MEM;
            end
            if (wq_empty || slot == SLOT_DRAIN) begin
                streak_q <= '0;
            end else if (slot == SLOT_READ && streak_q != STREAK_MAX) begin
                streak_q <= streak_q + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_port_sched.sv
// Directed bench for regfile_port_sched with a behavioural register file.
module tb_regfile_port_sched;
    import pc_regs_pkg::*;

    localparam int WQ_DEPTH        = 4;
    localparam int MAX_READ_STREAK = 8;
    localparam int NV              = 20;

    typedef struct {
        logic     rv;
        reg_idx_t rs1;
        reg_idx_t rs2;
        logic     av;
        reg_idx_t ard;
        word_t    adat;
        logic     mv;
        reg_idx_t mrd;
        word_t    mdat;
        logic     e_rdy;
        logic     e_ardy;
        logic     e_mrdy;
        logic     e_we;
        reg_idx_t e_ab;
        word_t    e_din;
        int       e_lvl;
        logic     e_rspv;
        word_t    e_ra;
        word_t    e_rb;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    word_t rf [32];
    vec_t  vecs [NV];
    int    checks = 0;
    int    errors = 0;

    regfile_port_sched_if #(.WQ_DEPTH(WQ_DEPTH)) bus ();

    regfile_port_sched #(
        .WQ_DEPTH        (WQ_DEPTH),
        .MAX_READ_STREAK (MAX_READ_STREAK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Register file: combinational reads, x0 never written.
    always @(posedge clk) begin
        if (bus.rf_we && bus.rf_addr_b != REG_ZERO) rf[bus.rf_addr_b] <= bus.rf_din;
    end

    always_comb begin
        bus.rf_reg_a = rf[bus.rf_addr_a];
        bus.rf_reg_b = rf[bus.rf_addr_b];
    end

    function automatic vec_t mkv(int unsigned rv, int unsigned rs1, int unsigned rs2,
                                 int unsigned av, int unsigned ard, int unsigned adat,
                                 int unsigned mv, int unsigned mrd, int unsigned mdat,
                                 int unsigned rdy, int unsigned ardy, int unsigned mrdy,
                                 int unsigned we, int unsigned ab, int unsigned din, int unsigned lvl,
                                 int unsigned rspv, int unsigned ra, int unsigned rb);
        vec_t v;
        v.rv     = (rv != 0);
        v.rs1    = reg_idx_t'(rs1);
        v.rs2    = reg_idx_t'(rs2);
        v.av     = (av != 0);
        v.ard    = reg_idx_t'(ard);
        v.adat   = adat;
        v.mv     = (mv != 0);
        v.mrd    = reg_idx_t'(mrd);
        v.mdat   = mdat;
        v.e_rdy  = (rdy != 0);
        v.e_ardy = (ardy != 0);
        v.e_mrdy = (mrdy != 0);
        v.e_we   = (we != 0);
        v.e_ab   = reg_idx_t'(ab);
        v.e_din  = din;
        v.e_lvl  = int'(lvl);
        v.e_rspv = (rspv != 0);
        v.e_ra   = ra;
        v.e_rb   = rb;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.rd_req_valid = v.rv;
        bus.rd_rs1       = v.rs1;
        bus.rd_rs2       = v.rs2;
        bus.alu_wb_valid = v.av;
        bus.alu_wb_rd    = v.ard;
        bus.alu_wb_data  = v.adat;
        bus.mem_wb_valid = v.mv;
        bus.mem_wb_rd    = v.mrd;
        bus.mem_wb_data  = v.mdat;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic checkVector(input int i, input vec_t v);
        checkOutput($sformatf("v%0d.rd_req_ready", i), 32'(bus.rd_req_ready), 32'(v.e_rdy));
        checkOutput($sformatf("v%0d.alu_wb_ready", i), 32'(bus.alu_wb_ready), 32'(v.e_ardy));
        checkOutput($sformatf("v%0d.mem_wb_ready", i), 32'(bus.mem_wb_ready), 32'(v.e_mrdy));
        checkOutput($sformatf("v%0d.rf_we", i), 32'(bus.rf_we), 32'(v.e_we));
        checkOutput($sformatf("v%0d.wq_level", i), 32'(bus.wq_level), 32'(v.e_lvl));
        checkOutput($sformatf("v%0d.rd_rsp_valid", i), 32'(bus.rd_rsp_valid), 32'(v.e_rspv));
        checkOutput($sformatf("v%0d.rd_rsp_a", i), bus.rd_rsp_a, v.e_ra);
        checkOutput($sformatf("v%0d.rd_rsp_b", i), bus.rd_rsp_b, v.e_rb);
        if (v.e_rdy || v.e_we)
            checkOutput($sformatf("v%0d.rf_addr_b", i), 32'(bus.rf_addr_b), 32'(v.e_ab));
        if (v.e_we)
            checkOutput($sformatf("v%0d.rf_din", i), bus.rf_din, v.e_din);
        if (v.e_rdy)
            checkOutput($sformatf("v%0d.rf_addr_a", i), 32'(bus.rf_addr_a), 32'(v.rs1));
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int reads_before;
        int drain_at;
        int drains;
        int waited;
        int we_seen;

        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : 32'h100 + 32'(i);

        //           rv rs1 rs2 av ard adat          mv mrd mdat     rdy ardy mrdy we ab din           lvl rspv ra            rb
        vecs[0]  = mkv(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 1, 0, 0, 0, 0,            0, 0, 0,            0);
        vecs[1]  = mkv(1, 5, 0, 0, 0, 0,            0, 0, 0,        1, 0, 0, 0, 0, 0,            1, 0, 0,            0);
        vecs[2]  = mkv(0, 0, 0, 0, 0, 0,            0, 0, 0,        0, 0, 0, 1, 5, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 0);
        vecs[3]  = mkv(1, 5, 6, 0, 0, 0,            0, 0, 0,        1, 0, 0, 0, 6, 0,            0, 0, 32'hDEADBEEF, 0);
        vecs[4]  = mkv(0, 0, 0, 0, 0, 0,            0, 0, 0,        0, 0, 0, 0, 0, 0,            0, 1, 32'hDEADBEEF, 32'h106);
        vecs[5]  = mkv(0, 0, 0, 1, 3, 1,            1, 3, 2,        0, 0, 1, 0, 0, 0,            0, 0, 32'hDEADBEEF, 32'h106);
        vecs[6]  = mkv(0, 0, 0, 1, 3, 1,            0, 0, 0,        0, 1, 0, 1, 3, 2,            1, 0, 32'hDEADBEEF, 32'h106);
        vecs[7]  = mkv(0, 0, 0, 0, 0, 0,            0, 0, 0,        0, 0, 0, 1, 3, 1,            1, 0, 32'hDEADBEEF, 32'h106);
        vecs[8]  = mkv(1, 3, 0, 0, 0, 0,            0, 0, 0,        1, 0, 0, 0, 0, 0,            0, 0, 32'hDEADBEEF, 32'h106);
        vecs[9]  = mkv(0, 0, 0, 0, 0, 0,            0, 0, 0,        0, 0, 0, 0, 0, 0,            0, 1, 1,            0);
        vecs[10] = mkv(0, 0, 0, 1, 9, 32'hAAAA,     0, 0, 0,        0, 1, 0, 0, 0, 0,            0, 0, 1,            0);
        vecs[11] = mkv(1, 9, 9, 1, 9, 32'hBBBB,     0, 0, 0,        1, 1, 0, 0, 9, 0,            1, 0, 1,            0);
        vecs[12] = mkv(1, 9, 4, 0, 0, 0,            0, 0, 0,        1, 0, 0, 0, 4, 0,            2, 1, 32'hAAAA,     32'hAAAA);
        vecs[13] = mkv(0, 0, 0, 0, 0, 0,            0, 0, 0,        0, 0, 0, 1, 9, 32'hAAAA,     2, 1, 32'hBBBB,     32'h104);
        vecs[14] = mkv(0, 0, 0, 0, 0, 0,            0, 0, 0,        0, 0, 0, 1, 9, 32'hBBBB,     1, 0, 32'hBBBB,     32'h104);
        vecs[15] = mkv(1, 9, 0, 0, 0, 0,            0, 0, 0,        1, 0, 0, 0, 0, 0,            0, 0, 32'hBBBB,     32'h104);
        vecs[16] = mkv(0, 0, 0, 0, 0, 0,            0, 0, 0,        0, 0, 0, 0, 0, 0,            0, 1, 32'hBBBB,     0);
        vecs[17] = mkv(0, 0, 0, 0, 0, 0,            1, 0, 32'hFFFF, 0, 0, 1, 0, 0, 0,            0, 0, 32'hBBBB,     0);
        vecs[18] = mkv(1, 0, 0, 0, 0, 0,            0, 0, 0,        1, 0, 0, 0, 0, 0,            0, 0, 32'hBBBB,     0);
        vecs[19] = mkv(0, 0, 0, 0, 0, 0,            0, 0, 0,        0, 0, 0, 0, 0, 0,            0, 1, 0,            0);

        // Reset state, with decode already asking for operands.
        applyStimulus(mkv(1, 7, 9, 1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        checkOutput("reset.wq_level", 32'(bus.wq_level), 32'd0);
        checkOutput("reset.rd_rsp_valid", 32'(bus.rd_rsp_valid), 32'd0);
        checkOutput("reset.rf_we", 32'(bus.rf_we), 32'd0);
        checkOutput("reset.rf_addr_a", 32'(bus.rf_addr_a), 32'd0);
        checkOutput("reset.rf_addr_b", 32'(bus.rf_addr_b), 32'd0);
        checkOutput("reset.rf_din", bus.rf_din, 32'd0);
        checkOutput("reset.rd_rsp_a", bus.rd_rsp_a, 32'd0);
        checkOutput("reset.rd_rsp_b", bus.rd_rsp_b, 32'd0);
        applyStimulus(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        nextCycle();

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkVector(i, vecs[i]);
            nextCycle();
        end

        // Fill the queue while decode reads continuously; the fifth write rides a forced drain.
        for (int c = 0; c < 7; c++) begin
            applyStimulus(mkv(1, 1, 2, (c < 5) ? 1 : 0, 10 + c, 32'hA0 + c, 0, 0, 0,
                              0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
            checkOutput($sformatf("full.c%0d.wq_level", c), 32'(bus.wq_level),
                        (c < 4) ? 32'(c) : ((c < 6) ? 32'd4 : 32'd3));
            checkOutput($sformatf("full.c%0d.rd_req_ready", c), 32'(bus.rd_req_ready),
                        (c == 4 || c == 5) ? 32'd0 : 32'd1);
            checkOutput($sformatf("full.c%0d.rf_we", c), 32'(bus.rf_we),
                        (c == 4 || c == 5) ? 32'd1 : 32'd0);
            if (c < 5) checkOutput($sformatf("full.c%0d.alu_wb_ready", c), 32'(bus.alu_wb_ready), 32'd1);
            if (c == 4 || c == 5) begin
                checkOutput($sformatf("full.c%0d.rf_addr_b", c), 32'(bus.rf_addr_b), 32'(6 + c));
                checkOutput($sformatf("full.c%0d.rf_din", c), bus.rf_din, 32'h9C + 32'(c));
            end
            nextCycle();
        end
        applyStimulus(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        waited = 0;
        while (bus.wq_level != '0 && waited < 10) begin
            nextCycle();
            waited++;
            checkOutput("full.level_bound", 32'(bus.wq_level <= 3'd4), 32'd1);
        end
        checkOutput("full.drain_timeout", 32'(bus.wq_level), 32'd0);
        for (int k = 0; k < 5; k++)
            checkOutput($sformatf("full.rf_x%0d", 10 + k), rf[10 + k], 32'hA0 + 32'(k));

        // One queued write under 20 cycles of read pressure: 8 reads, one drain, reads again.
        applyStimulus(mkv(0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput("starve.enq_ready", 32'(bus.alu_wb_ready), 32'd1);
        nextCycle();
        applyStimulus(mkv(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reads_before = 0;
        drain_at     = -1;
        drains       = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rf_we) begin
                drains++;
                if (drain_at < 0) begin
                    drain_at = i;
                    checkOutput("starve.drain_rd_req_ready", 32'(bus.rd_req_ready), 32'd0);
                    checkOutput("starve.drain_addr", 32'(bus.rf_addr_b), 32'd7);
                end
            end else if (bus.rd_req_ready && drain_at < 0) begin
                reads_before++;
            end
            if (i == 9) begin
                checkOutput("starve.resume_ready", 32'(bus.rd_req_ready), 32'd1);
                checkOutput("starve.resume_level", 32'(bus.wq_level), 32'd0);
            end
            nextCycle();
        end
        checkOutput("starve.reads_before_drain", 32'(reads_before), 32'd8);
        checkOutput("starve.drain_index", 32'(drain_at), 32'd8);
        checkOutput("starve.drain_count", 32'(drains), 32'd1);
        checkOutput("starve.rf_x7", rf[7], 32'h77);

        // Reset mid-stream with a write to x5 queued and a read response due.
        applyStimulus(mkv(1, 1, 2, 1, 5, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput("rst.enq_ready", 32'(bus.alu_wb_ready), 32'd1);
        nextCycle();
        applyStimulus(mkv(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst.async_level", 32'(bus.wq_level), 32'd0);
        checkOutput("rst.async_rsp_valid", 32'(bus.rd_rsp_valid), 32'd0);
        nextCycle();
        checkOutput("rst.edge_level", 32'(bus.wq_level), 32'd0);
        checkOutput("rst.edge_rsp_valid", 32'(bus.rd_rsp_valid), 32'd0);
        checkOutput("rst.edge_rf_we", 32'(bus.rf_we), 32'd0);
        applyStimulus(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        we_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rf_we) we_seen++;
        end
        checkOutput("rst.no_stale_writes", 32'(we_seen), 32'd0);
        checkOutput("rst.rf_x5", rf[5], 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_port_sched.md
Name: regfile_port_sched

Overview:
- Sole owner of the general-purpose register file ports: drives we, addr_a, addr_b and din, and samples reg_a and reg_b.
- The register file shares addr_b between write and second read, so each cycle is either a read slot (two operands) or a write slot (one writeback).
- This block buffers writebacks from the ALU and memory stages, serves decode operand reads with bypass from the buffer, and bounds starvation in both directions.

Parameters:
- WQ_DEPTH, 4: write-queue entries; power of two, 2..16.
- MAX_READ_STREAK, 8: consecutive read slots allowed while the queue is non-empty before one drain slot is forced.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rd_req_valid  in  1  decode requests operands.
- rd_req_ready  out  1  read slot granted this cycle.
- rd_rs1  in  5  first source index.
- rd_rs2  in  5  second source index.
- rd_rsp_valid  out  1  operands valid; one cycle after the handshake.
- rd_rsp_a  out  32  rs1 value.
- rd_rsp_b  out  32  rs2 value.
- alu_wb_valid  in  1  ALU writeback offered.
- alu_wb_ready  out  1  ALU writeback accepted.
- alu_wb_rd  in  5  ALU destination index.
- alu_wb_data  in  32  ALU result.
- mem_wb_valid  in  1  load writeback offered.
- mem_wb_ready  out  1  load writeback accepted.
- mem_wb_rd  in  5  load destination index.
- mem_wb_data  in  32  load data.
- rf_we  out  1  register-file write enable.
- rf_addr_a  out  5  register-file read-port A address.
- rf_addr_b  out  5  register-file read-port B / write address.
- rf_din  out  32  register-file write data.
- rf_reg_a  in  32  register-file read data A (combinational).
- rf_reg_b  in  32  register-file read data B (combinational).
- wq_level  out  log2(WQ_DEPTH)+1  queue occupancy.

Behaviour:
- Reset values: queue empty; wq_level=0; rd_rsp_valid=0; rd_rsp_a/b=0; rf_we=0; rf_addr_a/b=0; rf_din=0; streak=0; round-robin pointer favours mem.
- Reset asserted mid-operation discards all queued writes and any response due next cycle.

Enqueue:
- At most one writeback is accepted per cycle.
- If both sources are valid, round-robin decides; the pointer flips to the other source after each grant.
- A lone valid source is always granted if space allows.
- ready = grant & (queue not full, or a drain occurs this cycle).
- A writeback with rd=0 is accepted (ready=1) but never enqueued.

Slot choice each cycle (combinational):
- Drain slot when the queue is non-empty and any of these holds: rd_req_valid=0; queue full; streak = MAX_READ_STREAK.
- Otherwise, read slot when rd_req_valid=1.
- Otherwise idle.

Read slot:
- rd_req_ready=1, rf_we=0, rf_addr_a=rd_rs1, rf_addr_b=rd_rs2.
- Each operand resolves with this priority:
  - index 0 gives 0;
  - else the youngest queue entry with a matching rd;
  - else rf_reg_x.
- Resolved values are registered; rd_rsp_valid pulses at edge+1. Fixed latency of 1; there is no response backpressure.
- A writeback accepted in the same cycle as the read is not bypassed. Decode must not issue a read that depends on an in-flight write until that write has been accepted.

Drain slot:
- rf_we=1, rf_addr_b=head.rd, rf_din=head.data; head is popped at the edge.
- rd_req_ready=0; rf_addr_a is held at rd_rs1.

Idle: rf_we=0 and rd_req_ready=0.

Streak counter:
- Increments on each read slot taken while the queue is non-empty.
- Clears on any drain slot or whenever the queue is empty.
- Saturates at MAX_READ_STREAK.

Simultaneous events:
- Enqueue and drain in the same cycle: wq_level is unchanged.
- Full queue plus a drain: one enqueue is still accepted.
- Queue ordering is FIFO. Two queued writes to the same rd retire in program order, and bypass selects the younger one.

Decomposition:
- Shared package pc_regs_pkg:
  - reg_idx_t (5 bits), word_t (32 bits);
  - wq_entry_t struct {reg_idx_t rd; word_t data};
  - localparam REG_ZERO=0.
- Sub-module regfile_wq:
  - circular FIFO of wq_entry_t with push, pop, full, empty and level;
  - two combinational youngest-match lookup ports (idx in, hit out, data out);
  - uses wrap-around pointers with one extra bit.

Test Plan:
- Reset with pending traffic: assert rst low mid-stream -> wq_level=0, rd_rsp_valid=0, rf_we=0 on the following edge; any previously queued write to x5 never appears on the rf bus.
- Bypass: ALU writes x5=0xDEADBEEF; the next cycle decode reads rs1=5, rs2=0 -> rd_rsp_a=0xDEADBEEF, rd_rsp_b=0 one cycle later, before the entry drains. After draining, the same read returns the register-file value 0xDEADBEEF.
- Round-robin and ordering:
  - ALU(x3=1) and mem(x3=2) are both valid in cycle 0 -> mem is granted first, ALU in cycle 1.
  - With no reads pending, the rf bus sees x3<=2 then x3<=1; a subsequent read of x3 returns 1.
- Full queue: 4 writes queued while reads are held continuously -> the 5th write sees ready=0 until a forced drain. rd_req_ready drops while full; wq_level never exceeds 4.
- Starvation bound: queue holds 1 entry and rd_req_valid=1 for 20 cycles -> exactly 8 read slots, then 1 drain slot (rf_we=1, rd_req_ready=0), then reads resume with the queue empty.
- x0 handling: mem write rd=0 data=0xFFFF -> mem_wb_ready=1, wq_level stays 0, rf_we never asserts. Reading x0 returns 0.
